pid_sample_sequencer: RTL and testbench

PID_SAMPLE_SEQUENCER -- requirements
Module: pid_sample_sequencer

---
 rtl/pid_pkg.sv | 33 +++
 rtl/sample_tick_gen.sv | 37 +++
 rtl/pid_sample_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_pid_sample_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared definitions for the PID sample sequencer: state encoding, gain
// select codes and power-on gain values.
package pid_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT_FB = 3'd1,
      ST_COMPUTE = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_COMMIT  = 3'd4,
      ST_FAULT   = 3'd5
   } pid_state_e;

   typedef enum logic [1:0] {
      CFG_KP   = 2'd0,
      CFG_KI   = 2'd1,
      CFG_KD   = 2'd2,
      CFG_RSVD = 2'd3
   } cfg_sel_e;

   typedef struct packed {
      logic [15:0] kp;
      logic [15:0] ki;
      logic [15:0] kd;
   } gains_t;

   // kp = 0x0100 is unity gain in the controller's 8.8 fixed-point format.
   localparam logic [15:0] KP_DEFAULT = 16'h0100;
   localparam logic [15:0] KI_DEFAULT = 16'h0000;
   localparam logic [15:0] KD_DEFAULT = 16'h0000;
   localparam gains_t      GAINS_DEFAULT = {KP_DEFAULT, KI_DEFAULT, KD_DEFAULT};

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample divider: counts 0..SAMPLE_DIV-1 while run is high and
// emits a one-cycle tick on the wrap back to zero.
module sample_tick_gen #(
   parameter int unsigned SAMPLE_DIV = 27000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic tick
);

   localparam int unsigned CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          wrap;

   assign wrap = (cnt_q == CW'(SAMPLE_DIV - 1));
   assign tick = run & wrap;

   always_comb begin
      cnt_d = cnt_q;
      if (!run || wrap) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pid_sample_sequencer.sv
// Sequences one PID control sample per tick: collect feedback, present the
// saturated error, strobe the controller, wait for it to settle, publish.
module pid_sample_sequencer
   import pid_pkg::*;
#(
   parameter int unsigned SAMPLE_DIV = 27000,
   parameter int unsigned SETTLE_CYC = 3,
   parameter int unsigned FB_TIMEOUT = 1024,
   parameter int unsigned DATA_W     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     run,
   input  logic signed [DATA_W-1:0] setpoint,
   input  logic                     fb_valid,
   input  logic signed [DATA_W-1:0] fb_data,
   output logic                     fb_ready,
   input  logic                     cfg_wr,
   input  logic [1:0]               cfg_sel,
   input  logic [15:0]              cfg_data,
   output logic                     cfg_ack,
   output logic [15:0]              pid_kp,
   output logic [15:0]              pid_ki,
   output logic [15:0]              pid_kd,
   output logic signed [DATA_W-1:0] pid_error,
   output logic                     pid_en,
   output logic                     pid_rst,
   input  logic signed [DATA_W-1:0] pid_result,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_valid,
   output logic                     fault,
   output logic                     busy,
   output pid_state_e               dbg_state_o
);

   localparam int unsigned TCW = $clog2(FB_TIMEOUT + 1);
   localparam int unsigned SCW = $clog2(SETTLE_CYC + 1);
   localparam logic signed [DATA_W-1:0] ERR_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] ERR_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   // Handshakes: feedback is accepted in the single cycle where the sequencer
   // waits in WAIT_FB and fb_valid is high; fb_ready is that acceptance strobe
   // (no back-pressure beyond it). out_valid is a one-cycle strobe with
   // out_data stable in the same cycle; there is no downstream ready.

   function automatic logic signed [DATA_W-1:0] sat_sub(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b
   );
      logic signed [DATA_W:0] diff;
      diff = {a[DATA_W-1], a} - {b[DATA_W-1], b};
      if (diff[DATA_W] != diff[DATA_W-1]) begin
         sat_sub = diff[DATA_W] ? ERR_MIN : ERR_MAX;
      end else begin
         sat_sub = diff[DATA_W-1:0];
      end
   endfunction

   // Reset asserts asynchronously and releases through two flops; pid_rst
   // alone sits on the raw reset so it drops on the first clock after release.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n = rst_sync_q[1];

   logic tick;

   sample_tick_gen #(
      .SAMPLE_DIV(SAMPLE_DIV)
   ) u_tick (
      .clk  (clk),
      .rst_n(rst_n),
      .run  (run),
      .tick (tick)
   );

   pid_state_e                state_q, state_d;
   logic [TCW-1:0]            wait_cnt_q, wait_cnt_d;
   logic [SCW-1:0]            settle_cnt_q, settle_cnt_d;
   logic signed [DATA_W-1:0]  err_q, err_d;
   logic signed [DATA_W-1:0]  out_data_q, out_data_d;
   logic                      fresh_q, fresh_d;
   logic                      cfg_ack_q;
   logic                      pid_rst_q, rst_pulse_d;
   logic                      apply_gains;
   gains_t                    shadow_q, shadow_d, gains_q, gains_d;

   assign busy = (state_q == ST_WAIT_FB) || (state_q == ST_COMPUTE) ||
                 (state_q == ST_SETTLE)  || (state_q == ST_COMMIT);

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      settle_cnt_d = settle_cnt_q;
      err_d        = err_q;
      out_data_d   = out_data_q;
      fresh_d      = fresh_q;
      rst_pulse_d  = 1'b0;
      fb_ready     = 1'b0;
      pid_en       = 1'b0;
      out_valid    = 1'b0;
      apply_gains  = 1'b0;
      if (!run) begin
         fresh_d = 1'b1;
      end
      case (state_q)
         ST_IDLE: begin
            wait_cnt_d  = '0;
            apply_gains = !run;
            if (run && tick) begin
               state_d     = ST_WAIT_FB;
               rst_pulse_d = fresh_q;
               fresh_d     = 1'b0;
            end
         end
         ST_WAIT_FB: begin
            if (fb_valid) begin
               fb_ready = 1'b1;
               err_d    = sat_sub(setpoint, fb_data);
               state_d  = ST_COMPUTE;
            end else if (wait_cnt_q == TCW'(FB_TIMEOUT - 1)) begin
               state_d     = ST_FAULT;
               out_data_d  = '0;
               rst_pulse_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         ST_COMPUTE: begin
            pid_en       = 1'b1;
            settle_cnt_d = '0;
            state_d      = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_cnt_q == SCW'(SETTLE_CYC - 1)) begin
               out_data_d = pid_result;
               state_d    = ST_COMMIT;
            end else begin
               settle_cnt_d = settle_cnt_q + 1'b1;
            end
         end
         ST_COMMIT: begin
            out_valid   = 1'b1;
            apply_gains = 1'b1;
            state_d     = ST_IDLE;
         end
         ST_FAULT: begin
            out_data_d  = '0;
            rst_pulse_d = 1'b1;
            if (!run) begin
               state_d     = ST_IDLE;
               rst_pulse_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Losing run mid-sequence wins over everything the sequence would do.
      if (!run && busy) begin
         state_d     = ST_IDLE;
         rst_pulse_d = 1'b1;
         err_d       = err_q;
         out_data_d  = out_data_q;
         fb_ready    = 1'b0;
         pid_en      = 1'b0;
         out_valid   = 1'b0;
         apply_gains = 1'b0;
      end
   end

   always_comb begin
      shadow_d = shadow_q;
      if (cfg_wr) begin
         case (cfg_sel_e'(cfg_sel))
            CFG_KP:  shadow_d.kp = cfg_data;
            CFG_KI:  shadow_d.ki = cfg_data;
            CFG_KD:  shadow_d.kd = cfg_data;
            default: shadow_d = shadow_q;
         endcase
      end
      gains_d = apply_gains ? shadow_d : gains_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         wait_cnt_q   <= '0;
         settle_cnt_q <= '0;
         err_q        <= '0;
         out_data_q   <= '0;
         fresh_q      <= 1'b1;
         cfg_ack_q    <= 1'b0;
         shadow_q     <= GAINS_DEFAULT;
         gains_q      <= '0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         err_q        <= err_d;
         out_data_q   <= out_data_d;
         fresh_q      <= fresh_d;
         cfg_ack_q    <= cfg_wr;
         shadow_q     <= shadow_d;
         gains_q      <= gains_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pid_rst_q <= 1'b1;
      end else begin
         pid_rst_q <= rst_pulse_d;
      end
   end

   assign pid_rst     = pid_rst_q;
   assign cfg_ack     = cfg_ack_q;
   assign pid_kp      = gains_q.kp;
   assign pid_ki      = gains_q.ki;
   assign pid_kd      = gains_q.kd;
   assign pid_error   = err_q;
   assign out_data    = out_data_q;
   assign fault       = (state_q == ST_FAULT);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pid_sample_sequencer.sv
// Directed bench for pid_sample_sequencer with an expected-value scoreboard
// drained by a negedge monitor.
module tb_pid_sample_sequencer;
   import pid_pkg::*;

   localparam int unsigned SAMPLE_DIV = 4;
   localparam int unsigned SETTLE_CYC = 3;
   localparam int unsigned FB_TIMEOUT = 16;
   localparam int unsigned DATA_W     = 16;
   localparam int          LATENCY    = 2 + SETTLE_CYC;

   logic                     clk = 1'b0;
   logic                     reset = 1'b1;
   logic                     run = 1'b0;
   logic signed [DATA_W-1:0] setpoint = '0;
   logic                     fb_valid = 1'b0;
   logic signed [DATA_W-1:0] fb_data = '0;
   logic                     fb_ready;
   logic                     cfg_wr = 1'b0;
   logic [1:0]               cfg_sel = '0;
   logic [15:0]              cfg_data = '0;
   logic                     cfg_ack;
   logic [15:0]              pid_kp, pid_ki, pid_kd;
   logic signed [DATA_W-1:0] pid_error;
   logic                     pid_en;
   logic                     pid_rst;
   logic signed [DATA_W-1:0] pid_result = '0;
   logic signed [DATA_W-1:0] out_data;
   logic                     out_valid;
   logic                     fault;
   logic                     busy;
   pid_state_e               dbg_state;

   pid_sample_sequencer #(
      .SAMPLE_DIV(SAMPLE_DIV),
      .SETTLE_CYC(SETTLE_CYC),
      .FB_TIMEOUT(FB_TIMEOUT),
      .DATA_W    (DATA_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .setpoint   (setpoint),
      .fb_valid   (fb_valid),
      .fb_data    (fb_data),
      .fb_ready   (fb_ready),
      .cfg_wr     (cfg_wr),
      .cfg_sel    (cfg_sel),
      .cfg_data   (cfg_data),
      .cfg_ack    (cfg_ack),
      .pid_kp     (pid_kp),
      .pid_ki     (pid_ki),
      .pid_kd     (pid_kd),
      .pid_error  (pid_error),
      .pid_en     (pid_en),
      .pid_rst    (pid_rst),
      .pid_result (pid_result),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .fault      (fault),
      .busy       (busy),
      .dbg_state_o(dbg_state)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   logic [15:0] exp_err_q[$];
   logic [15:0] exp_out_q[$];
   int errors = 0;
   int checks = 0;
   int fb_cyc = -1000;
   int en_cnt = 0;
   int out_cnt = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (fb_ready) fb_cyc = cyc;
      if (pid_en) begin
         en_cnt++;
         if (exp_err_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pid_en_unexpected: got pid_en=1 error=0x%0h, required no strobe", pid_error);
         end else begin
            check("pid_error", 16'(pid_error), exp_err_q.pop_front());
         end
      end
      if (out_valid) begin
         out_cnt++;
         if (exp_out_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_valid_unexpected: got out_data=0x%0h, required no output", out_data);
         end else begin
            check("out_data", 16'(out_data), exp_out_q.pop_front());
            check("latency", 16'(cyc - fb_cyc), 16'(LATENCY));
         end
      end
   end

   // ---------------- driver helpers ----------------
   function automatic logic [15:0] sat(input int a, input int b);
      int d;
      d = a - b;
      if (d > 32767) d = 32767;
      else if (d < -32768) d = -32768;
      return 16'(d);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input pid_state_e s, input string name);
      int n;
      n = 0;
      while (dbg_state !== s && n < 64) begin
         step();
         n++;
      end
      check({"reach_", name}, 16'(dbg_state), 16'(s));
   endtask

   task automatic give_fb(input int sp, input int fb, input int delay);
      setpoint = 16'(sp);
      wait_state(ST_WAIT_FB, "wait_fb");
      repeat (delay) step();
      fb_data  = 16'(fb);
      fb_valid = 1'b1;
      exp_err_q.push_back(sat(sp, fb));
      step();
      fb_valid = 1'b0;
   endtask

   // kind: 0 plain, 1 kp write during SETTLE, 2 ki write in the COMMIT cycle
   task automatic run_seq(input int sp, input int fb, input int delay, input int res, input int kind);
      pid_result = 16'(res);
      exp_out_q.push_back(16'(res));
      give_fb(sp, fb, delay);
      if (kind == 1) begin
         wait_state(ST_SETTLE, "settle");
         cfg_wr = 1'b1; cfg_sel = 2'd0; cfg_data = 16'h0200;
         step();
         cfg_wr = 1'b0;
         check("ack_in_settle", 16'(cfg_ack), 16'd1);
         check("kp_hold_settle", pid_kp, 16'h0100);
      end
      if (kind == 2) begin
         wait_state(ST_COMMIT, "commit_wr");
         cfg_wr = 1'b1; cfg_sel = 2'd1; cfg_data = 16'h0033;
      end
      wait_state(ST_COMMIT, "commit");
      if (kind == 1) check("kp_hold_commit", pid_kp, 16'h0100);
      step();
      cfg_wr = 1'b0;
      if (kind == 1) check("kp_applied", pid_kp, 16'h0200);
      if (kind == 2) check("ki_same_cycle", pid_ki, 16'h0033);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pid_rst", 16'(pid_rst), 16'd1);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_out_data", 16'(out_data), 16'd0);
      check("rst_kp", pid_kp, 16'd0);
      check("rst_fault", 16'(fault), 16'd0);
      check("rst_error", 16'(pid_error), 16'd0);
      check("rst_out_valid", 16'(out_valid), 16'd0);
      check("rst_state", 16'(dbg_state), 16'(ST_IDLE));

      reset = 1'b1;
      step();
      check("pid_rst_release", 16'(pid_rst), 16'd0);
      repeat (4) step();
      check("kp_default", pid_kp, 16'h0100);
      check("ki_default", pid_ki, 16'h0000);
      check("kd_default", pid_kd, 16'h0000);

      // reserved select is acknowledged but changes nothing
      cfg_wr = 1'b1; cfg_sel = 2'd3; cfg_data = 16'hFFFF;
      step();
      cfg_wr = 1'b0;
      check("ack_rsvd", 16'(cfg_ack), 16'd1);
      check("kp_after_rsvd", pid_kp, 16'h0100);
      check("ki_after_rsvd", pid_ki, 16'h0000);
      check("kd_after_rsvd", pid_kd, 16'h0000);
      step();
      check("ack_one_cycle", 16'(cfg_ack), 16'd0);
      cfg_wr = 1'b1; cfg_sel = 2'd2; cfg_data = 16'h0005;
      step();
      cfg_wr = 1'b0;
      check("kd_idle_write", pid_kd, 16'h0005);

      // loop start: fresh-integrator pulse, then four control samples
      run = 1'b1;
      wait_state(ST_WAIT_FB, "first_wait");
      check("pid_rst_fresh", 16'(pid_rst), 16'd1);
      check("busy_wait_fb", 16'(busy), 16'd1);
      run_seq(1000, 400, 5, 16'h1234, 0);
      run_seq(32767, -32768, 3, -5, 1);
      run_seq(-32768, 32767, 2, 7, 2);
      run_seq(-100, 250, 10, 99, 0);
      check("out_count_4", 16'(out_cnt), 16'd4);

      // run dropped during SETTLE: abort, pulse pid_rst, no output
      give_fb(10, 3, 1);
      wait_state(ST_SETTLE, "settle_abort");
      run = 1'b0;
      step();
      check("abort_state", 16'(dbg_state), 16'(ST_IDLE));
      check("abort_pid_rst", 16'(pid_rst), 16'd1);
      check("abort_busy", 16'(busy), 16'd0);
      step();
      check("abort_rst_pulse_end", 16'(pid_rst), 16'd0);
      repeat (3) step();
      check("abort_no_out", 16'(out_cnt), 16'd4);
      check("en_count", 16'(en_cnt), 16'd5);

      // feedback never arrives
      run = 1'b1;
      wait_state(ST_WAIT_FB, "timeout_wait");
      check("pid_rst_fresh2", 16'(pid_rst), 16'd1);
      n = 0;
      while (dbg_state == ST_WAIT_FB && n < 64) begin
         step();
         n++;
      end
      check("timeout_cycles", 16'(n), 16'(FB_TIMEOUT));
      check("fault_state", 16'(dbg_state), 16'(ST_FAULT));
      check("fault_flag", 16'(fault), 16'd1);
      check("fault_out_zero", 16'(out_data), 16'd0);
      check("fault_pid_rst", 16'(pid_rst), 16'd1);
      check("fault_busy", 16'(busy), 16'd0);
      repeat (6) step();
      check("fault_sticky", 16'(fault), 16'd1);
      run = 1'b0;
      step();
      check("fault_exit_state", 16'(dbg_state), 16'(ST_IDLE));
      check("fault_cleared", 16'(fault), 16'd0);

      // async reset in WAIT_FB with a pending shadow write
      run = 1'b1;
      wait_state(ST_WAIT_FB, "reset_wait");
      cfg_wr = 1'b1; cfg_sel = 2'd2; cfg_data = 16'h0077;
      step();
      cfg_wr = 1'b0;
      check("kd_pending_hold", pid_kd, 16'h0005);
      #3 reset = 1'b0;
      #1;
      check("areset_pid_rst", 16'(pid_rst), 16'd1);
      check("areset_busy", 16'(busy), 16'd0);
      check("areset_state", 16'(dbg_state), 16'(ST_IDLE));
      check("areset_kp", pid_kp, 16'd0);
      check("areset_ki", pid_ki, 16'd0);
      check("areset_error", 16'(pid_error), 16'd0);
      check("areset_fb_ready", 16'(fb_ready), 16'd0);
      run = 1'b0;
      step();
      reset = 1'b1;
      repeat (5) step();
      check("shadow_discard_kd", pid_kd, 16'h0000);
      check("shadow_discard_kp", pid_kp, 16'h0100);
      check("exp_err_empty", 16'(exp_err_q.size()), 16'd0);
      check("exp_out_empty", 16'(exp_out_q.size()), 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
